// File: rtl/rv32i_wb_arbiter.sv
// Write-back arbiter and load scoreboard for the RV32I register file.
// Shares the single write port between the ALU result and load-return data.
// Load returns that lose the port wait in a small FIFO. A scoreboard of
// registers with outstanding loads drives the RAW/WAW pipeline stall.
module rv32i_wb_arbiter #(
  parameter int LOG2_QDEPTH = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   alu_wr_valid,
  input  logic [4:0]             alu_rd_idx,
  input  logic [31:0]            alu_rd,
  input  logic                   ld_issue,
  input  logic [4:0]             ld_issue_idx,
  input  logic                   ld_rtn_valid,
  input  logic [4:0]             ld_rtn_idx,
  input  logic [31:0]            ld_rtn_data,
  output logic                   ld_rtn_ready,
  input  logic [4:0]             dec_rs1_idx,
  input  logic [4:0]             dec_rs2_idx,
  output logic [4:0]             rd_idx,
  output logic [31:0]            new_rd,
  output logic                   stall,
  output logic [31:0]            busy_map,
  output logic [LOG2_QDEPTH:0]   q_count
);

  localparam int QDEPTH = 1 << LOG2_QDEPTH;
  localparam logic [LOG2_QDEPTH:0] FULL_CNT = (LOG2_QDEPTH+1)'(QDEPTH);

  // Queue storage and control
  logic [31:0]            q_data_q [QDEPTH];
  logic [4:0]             q_idx_q  [QDEPTH];
  logic [LOG2_QDEPTH-1:0] head_q, head_d;
  logic [LOG2_QDEPTH-1:0] tail_q, tail_d;
  logic [LOG2_QDEPTH:0]   count_q, count_d;

  // Write port and scoreboard
  logic [4:0]  rd_idx_q, rd_idx_d;
  logic [31:0] new_rd_q, new_rd_d;
  logic [31:0] busy_q, busy_d;

  logic q_full, q_empty, rtn_accept;
  logic alu_win, pop, bypass, push;

  assign q_full       = (count_q == FULL_CNT);
  assign q_empty      = (count_q == '0);
  assign ld_rtn_ready = !q_full && reset_n;
  assign rtn_accept   = ld_rtn_valid && ld_rtn_ready;

  // Winner selection: ALU first, then queue head, then a bypassed return.
  // Index-0 returns are accepted but neither pushed nor written.
  always_comb begin
    alu_win = alu_wr_valid && (alu_rd_idx != 5'd0) && !busy_q[alu_rd_idx];
    pop     = !alu_win && !q_empty;
    bypass  = !alu_win && q_empty && rtn_accept && (ld_rtn_idx != 5'd0);
    push    = rtn_accept && (ld_rtn_idx != 5'd0) && !bypass;
  end

  // Next-state for write port, queue pointers and scoreboard
  always_comb begin
    rd_idx_d = 5'd0;
    new_rd_d = 32'd0;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    busy_d   = busy_q;

    if (alu_win) begin
      rd_idx_d = alu_rd_idx;
      new_rd_d = alu_rd;
    end else if (pop) begin
      rd_idx_d = q_idx_q[head_q];
      new_rd_d = q_data_q[head_q];
    end else if (bypass) begin
      rd_idx_d = ld_rtn_idx;
      new_rd_d = ld_rtn_data;
    end

    if (pop)  head_d = head_q + LOG2_QDEPTH'(1);
    if (push) tail_d = tail_q + LOG2_QDEPTH'(1);
    if (push && !pop)      count_d = count_q + (LOG2_QDEPTH+1)'(1);
    else if (pop && !push) count_d = count_q - (LOG2_QDEPTH+1)'(1);

    // Clear first so a same-cycle set to the same index wins.
    if (pop || bypass) busy_d[rd_idx_d] = 1'b0;
    if (ld_issue && (ld_issue_idx != 5'd0) && !busy_q[ld_issue_idx])
      busy_d[ld_issue_idx] = 1'b1;
  end

  // Control registers; reset flushes the queue and forgets in-flight loads
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_idx_q <= 5'd0;
      new_rd_q <= 32'd0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      busy_q   <= 32'd0;
    end else begin
      rd_idx_q <= rd_idx_d;
      new_rd_q <= new_rd_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  // Queue storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      q_data_q[tail_q] <= ld_rtn_data;
      q_idx_q[tail_q]  <= ld_rtn_idx;
    end
  end

  // Hazard stall against outstanding loads; held low during reset
  always_comb begin
    stall = reset_n && (
              (busy_q[dec_rs1_idx] && (dec_rs1_idx != 5'd0)) ||
              (busy_q[dec_rs2_idx] && (dec_rs2_idx != 5'd0)) ||
              (alu_wr_valid && busy_q[alu_rd_idx]) ||
              (ld_issue && busy_q[ld_issue_idx]));
  end

  assign rd_idx   = rd_idx_q;
  assign new_rd   = new_rd_q;
  assign busy_map = busy_q;
  assign q_count  = count_q;

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// Directed bench for rv32i_wb_arbiter (queue depth 2).
module tb_rv32i_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_wr_valid;
  logic [4:0]  alu_rd_idx;
  logic [31:0] alu_rd;
  logic        ld_issue;
  logic [4:0]  ld_issue_idx;
  logic        ld_rtn_valid;
  logic [4:0]  ld_rtn_idx;
  logic [31:0] ld_rtn_data;
  logic        ld_rtn_ready;
  logic [4:0]  dec_rs1_idx;
  logic [4:0]  dec_rs2_idx;
  logic [4:0]  rd_idx;
  logic [31:0] new_rd;
  logic        stall;
  logic [31:0] busy_map;
  logic [1:0]  q_count;

  int total = 0;
  int bad   = 0;

  rv32i_wb_arbiter #(.LOG2_QDEPTH(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_wr_valid(alu_wr_valid), .alu_rd_idx(alu_rd_idx), .alu_rd(alu_rd),
    .ld_issue(ld_issue), .ld_issue_idx(ld_issue_idx),
    .ld_rtn_valid(ld_rtn_valid), .ld_rtn_idx(ld_rtn_idx),
    .ld_rtn_data(ld_rtn_data), .ld_rtn_ready(ld_rtn_ready),
    .dec_rs1_idx(dec_rs1_idx), .dec_rs2_idx(dec_rs2_idx),
    .rd_idx(rd_idx), .new_rd(new_rd), .stall(stall),
    .busy_map(busy_map), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wport(input string tag, input logic [4:0] ei, input logic [31:0] ed);
    check({tag, ".rd_idx"}, {27'd0, rd_idx}, {27'd0, ei});
    check({tag, ".new_rd"}, new_rd, ed);
  endtask

  task automatic alu(input logic v, input logic [4:0] i, input logic [31:0] d);
    alu_wr_valid = v; alu_rd_idx = i; alu_rd = d;
  endtask

  task automatic rtn(input logic v, input logic [4:0] i, input logic [31:0] d);
    ld_rtn_valid = v; ld_rtn_idx = i; ld_rtn_data = d;
  endtask

  task automatic issue(input logic v, input logic [4:0] i);
    ld_issue = v; ld_issue_idx = i;
  endtask

  initial begin
    reset_n = 1'b0;
    alu(0, 0, 0); rtn(0, 0, 0); issue(0, 0);
    dec_rs1_idx = 0; dec_rs2_idx = 0;
    #1;
    tick(); tick();
    check("rst.ready", {31'd0, ld_rtn_ready}, 0);
    check("rst.stall", {31'd0, stall}, 0);
    wport("rst", 0, 0);

    // Reset release: idle outputs, ready high
    reset_n = 1'b1;
    tick();
    wport("idle", 0, 0);
    check("idle.busy", busy_map, 0);
    check("idle.qcnt", {30'd0, q_count}, 0);
    check("idle.ready", {31'd0, ld_rtn_ready}, 1);

    // Load x5, bypassed return, RAW stall on rs1
    issue(1, 5);
    tick();
    issue(0, 0);
    check("ld5.busy", busy_map, 32'h20);
    dec_rs1_idx = 5;
    #1;
    check("ld5.stall", {31'd0, stall}, 1);
    rtn(1, 5, 32'hDEADBEEF);
    #1;
    check("ld5.ready", {31'd0, ld_rtn_ready}, 1);
    tick();
    rtn(0, 0, 0);
    #1;
    wport("ld5", 5, 32'hDEADBEEF);
    check("ld5.busy_clr", busy_map, 0);
    check("ld5.stall_clr", {31'd0, stall}, 0);
    dec_rs1_idx = 0;
    tick();
    wport("ld5.after", 0, 0);

    // Index-0 return is accepted and discarded; ALU x0 is ignored
    rtn(1, 0, 32'h77);
    alu(1, 0, 32'h66);
    #1;
    check("x0.ready", {31'd0, ld_rtn_ready}, 1);
    tick();
    rtn(0, 0, 0); alu(0, 0, 0);
    wport("x0", 0, 0);
    check("x0.qcnt", {30'd0, q_count}, 0);

    // Collision: ALU wins, return queued then drained
    alu(1, 3, 32'h22);
    rtn(1, 7, 32'h11);
    tick();
    alu(0, 0, 0); rtn(0, 0, 0);
    wport("col1", 3, 32'h22);
    check("col1.qcnt", {30'd0, q_count}, 1);
    tick();
    wport("col2", 7, 32'h11);
    check("col2.qcnt", {30'd0, q_count}, 0);

    // Queue fill with ALU busy every cycle
    alu(1, 1, 32'hA1);
    rtn(1, 8, 32'h88);
    tick();
    wport("fill1", 1, 32'hA1);
    check("fill1.qcnt", {30'd0, q_count}, 1);
    alu(1, 1, 32'hA2);
    rtn(1, 9, 32'h99);
    tick();
    wport("fill2", 1, 32'hA2);
    check("fill2.qcnt", {30'd0, q_count}, 2);
    alu(1, 1, 32'hA3);
    rtn(1, 10, 32'hAA);
    #1;
    check("fill3.ready", {31'd0, ld_rtn_ready}, 0);
    tick();
    wport("fill3", 1, 32'hA3);
    check("fill3.qcnt", {30'd0, q_count}, 2);
    alu(0, 0, 0);
    #1;
    check("drain1.ready", {31'd0, ld_rtn_ready}, 0);
    tick();
    wport("drain1", 8, 32'h88);
    check("drain1.qcnt", {30'd0, q_count}, 1);
    check("drain2.ready", {31'd0, ld_rtn_ready}, 1);
    tick();
    rtn(0, 0, 0);
    wport("drain2", 9, 32'h99);
    check("drain2.qcnt", {30'd0, q_count}, 1);
    tick();
    wport("drain3", 10, 32'hAA);
    check("drain3.qcnt", {30'd0, q_count}, 0);
    tick();
    wport("drain4", 0, 0);

    // WAW: ALU write to busy x4 is held until the load writes x4
    issue(1, 4);
    tick();
    issue(0, 0);
    check("waw.busy", busy_map, 32'h10);
    dec_rs2_idx = 4;
    #1;
    check("waw.rs2stall", {31'd0, stall}, 1);
    dec_rs2_idx = 0;
    alu(1, 4, 32'h5);
    #1;
    check("waw.stall", {31'd0, stall}, 1);
    tick();
    wport("waw.hold", 0, 0);
    rtn(1, 4, 32'h9);
    tick();
    rtn(0, 0, 0);
    #1;
    wport("waw.ld", 4, 32'h9);
    check("waw.busy_clr", busy_map, 0);
    check("waw.stall_clr", {31'd0, stall}, 0);
    tick();
    alu(0, 0, 0);
    wport("waw.alu", 4, 32'h5);
    tick();
    wport("waw.after", 0, 0);

    // Second load to a busy register stalls
    issue(1, 6);
    tick();
    #1;
    check("ld2.stall", {31'd0, stall}, 1);
    issue(0, 0);
    rtn(1, 6, 32'h6);
    tick();
    rtn(0, 0, 0);
    wport("ld2.rtn", 6, 32'h6);
    check("ld2.busy", busy_map, 0);

    // Reset with two queued entries and loads outstanding
    issue(1, 8); tick();
    issue(1, 9); tick();
    issue(0, 0);
    alu(1, 1, 32'hB1); rtn(1, 8, 32'h1234); tick();
    alu(1, 1, 32'hB2); rtn(1, 9, 32'h5678); tick();
    alu(0, 0, 0); rtn(0, 0, 0);
    check("pre.busy", busy_map, 32'h300);
    check("pre.qcnt", {30'd0, q_count}, 2);
    reset_n = 1'b0;
    dec_rs1_idx = 8;
    #1;
    check("mid.ready", {31'd0, ld_rtn_ready}, 0);
    check("mid.stall", {31'd0, stall}, 0);
    tick();
    wport("mid", 0, 0);
    check("mid.busy", busy_map, 0);
    check("mid.qcnt", {30'd0, q_count}, 0);
    reset_n = 1'b1;
    #1;
    check("post.ready", {31'd0, ld_rtn_ready}, 1);
    check("post.stall", {31'd0, stall}, 0);
    tick();
    wport("post1", 0, 0);
    tick();
    wport("post2", 0, 0);
    check("post.qcnt", {30'd0, q_count}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_wb_arbiter.md
# rv32i_wb_arbiter

Write-back arbiter and load scoreboard for the RV32I single-HART register file. It shares the register file's single write port between the ALU result path and out-of-band load-return data, and buffers load returns in a small FIFO when the ALU owns the port. It tracks registers with outstanding loads and generates the pipeline stall for RAW and WAW hazards against them. It sits between the execute stage, the data-memory interface and the register file write port (`rd_idx`/`new_rd`).

## Interface
Parameters:
- `LOG2_QDEPTH`, 1, log2 of the load-return queue depth (depth = 2^LOG2_QDEPTH).

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  reset; synchronous, active-low
- `alu_wr_valid`  in  1  ALU result write request
- `alu_rd_idx`  in  5  ALU destination register
- `alu_rd`  in  32  ALU result
- `ld_issue`  in  1  load issued to memory this cycle
- `ld_issue_idx`  in  5  destination of issued load
- `ld_rtn_valid`  in  1  load data valid
- `ld_rtn_idx`  in  5  destination of returned load
- `ld_rtn_data`  in  32  returned load data
- `ld_rtn_ready`  out  1  load return accepted when valid & ready
- `dec_rs1_idx`  in  5  decoder source 1 index
- `dec_rs2_idx`  in  5  decoder source 2 index
- `rd_idx`  out  5  register file write index (registered; 0 = no write)
- `new_rd`  out  32  register file write data (registered)
- `stall`  out  1  pipeline hold (combinational)
- `busy_map`  out  32  scoreboard; bit n = load outstanding to xn (registered)
- `q_count`  out  LOG2_QDEPTH+1  load queue occupancy (registered)

## Operation
- Winner select each cycle, in priority order:
  1. ALU: `alu_wr_valid` & `alu_rd_idx`≠0 & !`busy_map[alu_rd_idx]`.
  2. Queue head, if the queue is non-empty.
  3. Accepted load return, bypassing the queue, only when the queue is empty.
- No winner: `rd_idx`←0, `new_rd`←0.
- Accepted load return that is not the direct winner is pushed onto the queue tail. Push and pop in the same cycle are allowed.
- `ld_rtn_ready` = !full & `reset_n`. A full queue never accepts a return, including in a pop cycle.
- A return with `ld_rtn_idx`=0 is accepted and discarded (no push, no write).
- Scoreboard:
  - Set on `ld_issue` with `ld_issue_idx`≠0.
  - Cleared when a load write (winner 2 or 3) for that index is registered.
  - Set and clear to the same index in the same cycle: set wins.
- `stall` = any of:
  - `busy_map[dec_rs1_idx]` (idx≠0)
  - `busy_map[dec_rs2_idx]` (idx≠0)
  - `alu_wr_valid` & `busy_map[alu_rd_idx]` (WAW; ALU write suppressed)
  - `ld_issue` & `busy_map[ld_issue_idx]` (second load to a busy register; set ignored)
- Upstream holds `alu_*` and `ld_issue*` stable while `stall`=1.
- The write port is not qualified by `stall`. The register file must accept writes while the pipeline is stalled.
- Loads may return in any order. Queue order is FIFO.

## Timing
- Reset, every output: `rd_idx`=0, `new_rd`=0, `busy_map`=0, `q_count`=0, `ld_rtn_ready`=0, `stall`=0. The queue is flushed.
- Reset mid-operation discards queued and in-flight loads. The first cycle after reset deasserts has ready=1.
- ALU write latency: request in cycle N → `rd_idx`/`new_rd` valid in cycle N+1 for exactly one cycle.
- Bypassed load: 1 cycle, valid&ready at N → write visible at N+1.
- Queued load: written at the first cycle with no ALU winner, plus 1 cycle of output latency.
- `busy_map` clears on the same edge the load's `rd_idx` appears. `stall` drops combinationally in that cycle; the register file's own bypass supplies the data.
- `q_count` updates on the edge after the push/pop. Full = `q_count`==2^LOG2_QDEPTH.

## Test plan
- Reset then idle: `rd_idx`=0, `new_rd`=0, `busy_map`=0, `ld_rtn_ready`=1 on the first cycle after reset.
- Load x5 issued, return `0xDEADBEEF` with no ALU activity → `rd_idx`=5, `new_rd`=`0xDEADBEEF` next cycle. `busy_map[5]` goes 1 then 0. Decoder rs1=5 stalls until the clear.
- Collision: return x7=`0x11` while ALU writes x3=`0x22` → cycle N+1 shows x3/`0x22`, N+2 shows x7/`0x11`. `q_count` goes 1 then 0.
- Queue fill (depth 2): ALU writes every cycle, three returns x8,x9,x10 → ready=0 after two are accepted. Once ALU idles, writes drain in order x8, x9, then x10 (x10 accepted only after ready reasserts).
- WAW: x4 busy, ALU write x4=`0x5` → `stall`=1, no write. Return x4=`0x9` writes x4, then the ALU write `0x5` lands one cycle after the clear.
- Reset asserted with 2 queued entries and `busy_map`=`0x300` → all cleared, no write of queued data after reset.
